gate_admission_queue: RTL and testbench
=======================================

// Module: gate_admission_queue
// PURPOSE
//  Downstream of the security-check stage. Consumes each cleared passenger's
//  security_token, priority and parity, and drops tokens whose parity is bad.
//  Good tokens are buffered in separate VIP and normal queues. A gate FSM
//  admits one passenger per gate cycle, serving VIPs first with a starvation
//  guard, and locks the gate down after repeated parity failures.
// PARAMETERS
//  DEPTH        4   entries per queue (VIP and normal each), >=2
//  OPEN_CYCLES  3   cycles gate_open stays high per admitted passenger, >=1
//  STARVE_LIMIT 3   max consecutive VIP admits while normal queue non-empty, >=1
//  REJECT_LOCK  3   consecutive parity rejects that trigger lockdown, >=1
//  LOCK_CYCLES  8   lockdown duration in cycles, >=1
// PORTS
//  clk            in   1   single clock; all logic on posedge
//  reset          in   1   synchronous, active-low (0 = reset at posedge clk)
//  tok_valid      in   1   upstream has a token
//  tok_ready      out  1   block accepts token this cycle
//  security_token in   8   token from security stage
//  priority       in   2   00 normal, 01 crew, 10 VIP, 11 emergency
//  parity         in   1   expected even parity: must equal ^security_token
//  gate_open      out  1   gate actuator
//  admit_valid    out  1   1-cycle pulse: passenger admitted
//  admit_token    out  8   token of admitted passenger (held until next admit)
//  admit_vip      out  1   admitted passenger came from VIP queue
//  admit_count    out  8   admitted total, saturates at 255
//  reject_count   out  4   parity rejects total, saturates at 15
//  alarm          out  1   1-cycle pulse per parity reject
//  locked         out  1   high while in LOCK
//  vip_level      out  $clog2(DEPTH+1)  VIP queue occupancy
//  norm_level     out  $clog2(DEPTH+1)  normal queue occupancy
// BEHAVIOUR
//  Reset (reset==0 at edge): queues emptied, FSM=IDLE, all outputs 0,
//   vip_streak=0, reject_streak=0. Applies mid-operation; in-flight admit lost.
//  Handshake: transfer when tok_valid && tok_ready at posedge.
//   tok_ready = !locked && VIP not full && normal not full.
//  Accept classification: priority[1]==1 -> VIP queue, else normal queue.
//   Parity mismatch -> token dropped, alarm=1 next cycle, reject_count+1,
//   reject_streak+1. Good token -> reject_streak=0.
//  Lockdown: reject_streak reaching REJECT_LOCK -> FSM enters LOCK at the next
//   edge, even from OPEN (gate_open drops that cycle). reject_streak then clears.
//  FSM states: IDLE, OPEN, CLOSE, LOCK.
//   IDLE: if any queue non-empty -> OPEN and pop one entry at the same edge.
//     Select VIP if VIP non-empty && (normal empty || vip_streak<STARVE_LIMIT);
//     vip_streak+1 if normal non-empty, else vip_streak=0.
//     Otherwise pop normal and set vip_streak=0.
//   OPEN: gate_open=1 for OPEN_CYCLES cycles, then -> CLOSE.
//   CLOSE: 1 cycle with gate_open=0, then -> IDLE.
//   LOCK: gate_open=0, tok_ready=0, locked=1 for LOCK_CYCLES, then -> IDLE.
//     Queue contents are retained.
//  Latency: token accepted at edge E into empty queues with FSM in IDLE ->
//   admit_valid=1 and gate_open=1 from edge E+1. Minimum admit spacing is
//   OPEN_CYCLES+2 cycles.
//  admit_valid, admit_token and admit_vip are registered and update on the
//   edge entering OPEN.
//  Simultaneous push and pop on the same queue is legal; level is unchanged.
//  Pointers wrap modulo DEPTH. No push when full, no pop when empty.
//  Counters saturate; they never wrap.
// TESTING
//  1 Reset: hold reset=0 for 2 cycles while tok_valid=1 -> all outputs 0,
//    levels 0, nothing admitted.
//  2 Single normal: token 8'h3C, pri 00, parity 0 -> admit_valid one cycle
//    later with admit_token=3C, admit_vip=0; gate_open high 3 cycles, then 1
//    cycle low.
//  3 Priority/starvation: queue 2 normal (11,22) and 5 VIP (A1..A5) while in
//    OPEN -> admit order A1,A2,A3,11,A4,A5,22.
//  4 Parity reject: token 8'h01 with parity 0 -> alarm pulse, reject_count=1,
//    no admit, levels unchanged.
//  5 Lockdown: 3 consecutive bad tokens during OPEN -> locked=1 and gate_open=0
//    next edge; tok_ready=0 for 8 cycles; queued entries admitted afterwards.
//  6 Full/saturation: fill VIP to 4 -> tok_ready=0. Reset mid-OPEN -> gate_open=0
//    next edge. Force 16+ rejects -> reject_count holds 15.

Source files
------------

// File: rtl/gate_admission_queue.sv
// gate_admission_queue: buffers parity-checked security tokens in VIP and
// normal queues and admits one passenger per gate cycle through a gate FSM.
// VIPs are served first, bounded by a starvation guard for the normal queue.
// A run of consecutive parity rejects locks the gate for a fixed period.
//
// Ports
//   clk_i            clock, all logic on posedge
//   reset_i          synchronous active-low reset
//   tok_valid_i      upstream token valid
//   tok_ready_o      block accepts a token this cycle
//   security_token_i 8-bit token
//   priority_i       00 normal, 01 crew, 10 VIP, 11 emergency
//   parity_i         expected even parity (must equal ^security_token_i)
//   gate_open_o      gate actuator
//   admit_valid_o    one-cycle admit pulse
//   admit_token_o    token of last admitted passenger
//   admit_vip_o      last admitted passenger came from the VIP queue
//   admit_count_o    saturating admit total
//   reject_count_o   saturating parity reject total
//   alarm_o          one-cycle pulse per parity reject
//   locked_o         high while locked down
//   vip_level_o      VIP queue occupancy
//   norm_level_o     normal queue occupancy
module gate_admission_queue #(
    parameter int unsigned DEPTH        = 4,
    parameter int unsigned OPEN_CYCLES  = 3,
    parameter int unsigned STARVE_LIMIT = 3,
    parameter int unsigned REJECT_LOCK  = 3,
    parameter int unsigned LOCK_CYCLES  = 8
) (
    input  logic                       clk_i,
    input  logic                       reset_i,
    input  logic                       tok_valid_i,
    output logic                       tok_ready_o,
    input  logic [7:0]                 security_token_i,
    input  logic [1:0]                 priority_i,
    input  logic                       parity_i,
    output logic                       gate_open_o,
    output logic                       admit_valid_o,
    output logic [7:0]                 admit_token_o,
    output logic                       admit_vip_o,
    output logic [7:0]                 admit_count_o,
    output logic [3:0]                 reject_count_o,
    output logic                       alarm_o,
    output logic                       locked_o,
    output logic [$clog2(DEPTH+1)-1:0] vip_level_o,
    output logic [$clog2(DEPTH+1)-1:0] norm_level_o
);

    localparam int unsigned LVL_W    = $clog2(DEPTH + 1);
    localparam int unsigned PTR_W    = $clog2(DEPTH);
    localparam int unsigned CNT_MAX  = (LOCK_CYCLES > OPEN_CYCLES) ? LOCK_CYCLES : OPEN_CYCLES;
    localparam int unsigned CNT_W    = $clog2(CNT_MAX + 1);
    localparam int unsigned STREAK_W = $clog2(STARVE_LIMIT + 1);
    localparam int unsigned REJ_W    = $clog2(REJECT_LOCK + 1);

    typedef enum logic [1:0] {IDLE, OPEN, CLOSE, LOCK} state_e;

    state_e              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [7:0]          vip_mem [DEPTH];
    logic [7:0]          norm_mem [DEPTH];
    logic [PTR_W-1:0]    vip_rd_q, vip_rd_d, vip_wr_q, vip_wr_d;
    logic [PTR_W-1:0]    norm_rd_q, norm_rd_d, norm_wr_q, norm_wr_d;
    logic [LVL_W-1:0]    vip_lvl_q, vip_lvl_d, norm_lvl_q, norm_lvl_d;
    logic [STREAK_W-1:0] vip_streak_q, vip_streak_d;
    logic [REJ_W-1:0]    rej_streak_q, rej_streak_d;
    logic [7:0]          admit_cnt_q, admit_cnt_d;
    logic [3:0]          rej_cnt_q, rej_cnt_d;
    logic                admit_valid_q, admit_valid_d;
    logic [7:0]          admit_token_q, admit_token_d;
    logic                admit_vip_q, admit_vip_d;
    logic                alarm_q, alarm_d;
    logic                gate_open_q, gate_open_d;
    logic                locked_q, locked_d;
    logic                tok_ready_q, tok_ready_d;

    logic xfer, par_bad, push_vip, push_norm, pop_vip, pop_norm;
    logic vip_empty, norm_empty, lock_hit;
    logic unused_pri;

    // Crew and emergency share queues with normal and VIP respectively.
    assign unused_pri = priority_i[0];

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    assign xfer       = tok_valid_i && tok_ready_q;
    assign par_bad    = (parity_i != ^security_token_i);
    assign push_vip   = xfer && !par_bad && priority_i[1];
    assign push_norm  = xfer && !par_bad && !priority_i[1];
    assign vip_empty  = (vip_lvl_q == '0);
    assign norm_empty = (norm_lvl_q == '0);
    assign lock_hit   = (rej_streak_q >= REJ_W'(REJECT_LOCK));

    // Gate FSM next state, queue selection and admit outputs.
    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        pop_vip       = 1'b0;
        pop_norm      = 1'b0;
        vip_streak_d  = vip_streak_q;
        admit_valid_d = 1'b0;
        admit_token_d = admit_token_q;
        admit_vip_d   = admit_vip_q;
        admit_cnt_d   = admit_cnt_q;
        if (lock_hit) begin
            // Lockdown overrides any state, including an open gate.
            state_d = LOCK;
            cnt_d   = CNT_W'(LOCK_CYCLES - 1);
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (!vip_empty || !norm_empty) begin
                        state_d       = OPEN;
                        cnt_d         = CNT_W'(OPEN_CYCLES - 1);
                        admit_valid_d = 1'b1;
                        if (admit_cnt_q != 8'hFF) admit_cnt_d = admit_cnt_q + 8'd1;
                        if (!vip_empty && (norm_empty || vip_streak_q < STREAK_W'(STARVE_LIMIT))) begin
                            pop_vip       = 1'b1;
                            admit_token_d = vip_mem[vip_rd_q];
                            admit_vip_d   = 1'b1;
                            vip_streak_d  = norm_empty ? '0 : vip_streak_q + STREAK_W'(1);
                        end else begin
                            pop_norm      = 1'b1;
                            admit_token_d = norm_mem[norm_rd_q];
                            admit_vip_d   = 1'b0;
                            vip_streak_d  = '0;
                        end
                    end
                end
                OPEN: begin
                    if (cnt_q == '0) state_d = CLOSE;
                    else             cnt_d   = cnt_q - CNT_W'(1);
                end
                CLOSE: state_d = IDLE;
                LOCK: begin
                    if (cnt_q == '0) state_d = IDLE;
                    else             cnt_d   = cnt_q - CNT_W'(1);
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // Parity rejects, queue bookkeeping and registered status outputs.
    always_comb begin
        rej_streak_d = rej_streak_q;
        rej_cnt_d    = rej_cnt_q;
        alarm_d      = 1'b0;
        vip_rd_d     = vip_rd_q;
        vip_wr_d     = vip_wr_q;
        norm_rd_d    = norm_rd_q;
        norm_wr_d    = norm_wr_q;
        vip_lvl_d    = vip_lvl_q;
        norm_lvl_d   = norm_lvl_q;

        if (xfer) begin
            if (par_bad) begin
                alarm_d      = 1'b1;
                rej_streak_d = rej_streak_q + REJ_W'(1);
                if (rej_cnt_q != 4'hF) rej_cnt_d = rej_cnt_q + 4'd1;
            end else begin
                rej_streak_d = '0;
            end
        end
        if (lock_hit) rej_streak_d = '0;

        if (push_vip)  vip_wr_d  = ptr_inc(vip_wr_q);
        if (pop_vip)   vip_rd_d  = ptr_inc(vip_rd_q);
        if (push_norm) norm_wr_d = ptr_inc(norm_wr_q);
        if (pop_norm)  norm_rd_d = ptr_inc(norm_rd_q);

        case ({push_vip, pop_vip})
            2'b10:   vip_lvl_d = vip_lvl_q + LVL_W'(1);
            2'b01:   vip_lvl_d = vip_lvl_q - LVL_W'(1);
            default: vip_lvl_d = vip_lvl_q;
        endcase
        case ({push_norm, pop_norm})
            2'b10:   norm_lvl_d = norm_lvl_q + LVL_W'(1);
            2'b01:   norm_lvl_d = norm_lvl_q - LVL_W'(1);
            default: norm_lvl_d = norm_lvl_q;
        endcase

        // Status flags are computed from next state so they stay registered.
        gate_open_d = (state_d == OPEN);
        locked_d    = (state_d == LOCK);
        tok_ready_d = (state_d != LOCK) && (vip_lvl_d != LVL_W'(DEPTH)) && (norm_lvl_d != LVL_W'(DEPTH));
    end

    // Queue storage: contents need no reset, pointers and levels define validity.
    always_ff @(posedge clk_i) begin
        if (push_vip)  vip_mem[vip_wr_q]   <= security_token_i;
        if (push_norm) norm_mem[norm_wr_q] <= security_token_i;
    end

    // State and output registers.
    always_ff @(posedge clk_i) begin
        if (!reset_i) begin
            state_q       <= IDLE;
            cnt_q         <= '0;
            vip_rd_q      <= '0;
            vip_wr_q      <= '0;
            norm_rd_q     <= '0;
            norm_wr_q     <= '0;
            vip_lvl_q     <= '0;
            norm_lvl_q    <= '0;
            vip_streak_q  <= '0;
            rej_streak_q  <= '0;
            admit_cnt_q   <= '0;
            rej_cnt_q     <= '0;
            admit_valid_q <= 1'b0;
            admit_token_q <= '0;
            admit_vip_q   <= 1'b0;
            alarm_q       <= 1'b0;
            gate_open_q   <= 1'b0;
            locked_q      <= 1'b0;
            tok_ready_q   <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            vip_rd_q      <= vip_rd_d;
            vip_wr_q      <= vip_wr_d;
            norm_rd_q     <= norm_rd_d;
            norm_wr_q     <= norm_wr_d;
            vip_lvl_q     <= vip_lvl_d;
            norm_lvl_q    <= norm_lvl_d;
            vip_streak_q  <= vip_streak_d;
            rej_streak_q  <= rej_streak_d;
            admit_cnt_q   <= admit_cnt_d;
            rej_cnt_q     <= rej_cnt_d;
            admit_valid_q <= admit_valid_d;
            admit_token_q <= admit_token_d;
            admit_vip_q   <= admit_vip_d;
            alarm_q       <= alarm_d;
            gate_open_q   <= gate_open_d;
            locked_q      <= locked_d;
            tok_ready_q   <= tok_ready_d;
        end
    end

    assign tok_ready_o    = tok_ready_q;
    assign gate_open_o    = gate_open_q;
    assign admit_valid_o  = admit_valid_q;
    assign admit_token_o  = admit_token_q;
    assign admit_vip_o    = admit_vip_q;
    assign admit_count_o  = admit_cnt_q;
    assign reject_count_o = rej_cnt_q;
    assign alarm_o        = alarm_q;
    assign locked_o       = locked_q;
    assign vip_level_o    = vip_lvl_q;
    assign norm_level_o   = norm_lvl_q;

endmodule

// File: tb/tb_gate_admission_queue.sv
// Directed testbench for gate_admission_queue with hand-computed expectations.
module tb_gate_admission_queue;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       tok_valid = 1'b0;
    logic       tok_ready;
    logic [7:0] tok = '0;
    logic [1:0] pri = '0;
    logic       par = 1'b0;
    logic       gate_open, admit_valid, admit_vip, alarm, locked;
    logic [7:0] admit_token, admit_count;
    logic [3:0] reject_count;
    logic [2:0] vip_level, norm_level;

    int vec = 0;
    int miscmp = 0;

    logic [7:0] rec [16];
    int         rec_n = 0;

    gate_admission_queue dut (
        .clk_i            (clk),
        .reset_i          (reset_n),
        .tok_valid_i      (tok_valid),
        .tok_ready_o      (tok_ready),
        .security_token_i (tok),
        .priority_i       (pri),
        .parity_i         (par),
        .gate_open_o      (gate_open),
        .admit_valid_o    (admit_valid),
        .admit_token_o    (admit_token),
        .admit_vip_o      (admit_vip),
        .admit_count_o    (admit_count),
        .reject_count_o   (reject_count),
        .alarm_o          (alarm),
        .locked_o         (locked),
        .vip_level_o      (vip_level),
        .norm_level_o     (norm_level)
    );

    always #5 clk = ~clk;

    // Admit recorder for ordering checks.
    always @(negedge clk) begin
        if (admit_valid && rec_n < 16) begin
            rec[rec_n] <= admit_token;
            rec_n      <= rec_n + 1;
        end
    end

    // Called at a negedge; returns at the negedge after the transfer edge.
    task automatic push(input logic [7:0] t, input logic [1:0] p, input logic pb);
        int g = 0;
        tok = t; pri = p; par = pb; tok_valid = 1'b1;
        while (!tok_ready && g < 40) begin
            g++;
            @(negedge clk);
        end
        if (g >= 40) begin
            vec++; miscmp++;
            $display("FAIL push_timeout token=%h ready stayed 0", t);
        end
        @(posedge clk);
        @(negedge clk);
        tok_valid = 1'b0;
    endtask

    task automatic push_good(input logic [7:0] t, input logic [1:0] p);
        push(t, p, ^t);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset_n = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        rec_n = 0;
    endtask

    task automatic test_reset();
        @(negedge clk);
        reset_n = 1'b0; tok_valid = 1'b1; tok = 8'h3C; pri = 2'b10; par = 1'b0;
        @(negedge clk);
        @(negedge clk);
        vec++; if ({gate_open, admit_valid, admit_vip, alarm, locked, tok_ready} !== 6'b0) begin
            miscmp++; $display("FAIL reset_flags got=%b exp=000000", {gate_open, admit_valid, admit_vip, alarm, locked, tok_ready});
        end
        vec++; if ({admit_token, admit_count, reject_count} !== 20'h0) begin
            miscmp++; $display("FAIL reset_values got=%h/%h/%h exp=0", admit_token, admit_count, reject_count);
        end
        vec++; if ({vip_level, norm_level} !== 6'b0) begin
            miscmp++; $display("FAIL reset_levels got=%0d/%0d exp=0/0", vip_level, norm_level);
        end
        tok_valid = 1'b0; reset_n = 1'b1;
        @(negedge clk);
        vec++; if (tok_ready !== 1'b1 || admit_valid !== 1'b0 || admit_count !== 8'd0) begin
            miscmp++; $display("FAIL reset_release ready=%b admit=%b count=%0d exp 1/0/0", tok_ready, admit_valid, admit_count);
        end
    endtask

    task automatic test_single_normal();
        logic [3:0] gates;
        do_reset();
        push(8'h3C, 2'b00, 1'b0);
        vec++; if (admit_valid !== 1'b0 || norm_level !== 3'd1) begin
            miscmp++; $display("FAIL single_accept admit=%b lvl=%0d exp 0/1", admit_valid, norm_level);
        end
        @(negedge clk);
        vec++; if (admit_valid !== 1'b1 || admit_token !== 8'h3C || admit_vip !== 1'b0) begin
            miscmp++; $display("FAIL single_admit v=%b tok=%h vip=%b exp 1/3c/0", admit_valid, admit_token, admit_vip);
        end
        vec++; if (admit_count !== 8'd1 || norm_level !== 3'd0) begin
            miscmp++; $display("FAIL single_count cnt=%0d lvl=%0d exp 1/0", admit_count, norm_level);
        end
        gates[3] = gate_open;
        @(negedge clk);
        vec++; if (admit_valid !== 1'b0) begin
            miscmp++; $display("FAIL single_pulse admit_valid=%b exp 0", admit_valid);
        end
        gates[2] = gate_open;
        @(negedge clk); gates[1] = gate_open;
        @(negedge clk); gates[0] = gate_open;
        vec++; if (gates !== 4'b1110) begin
            miscmp++; $display("FAIL single_gate pattern=%b exp 1110", gates);
        end
    endtask

    task automatic test_priority_starve();
        logic [7:0] exp_ord [8];
        int g = 0;
        exp_ord = '{8'h00, 8'hA1, 8'hA2, 8'hA3, 8'h11, 8'hA4, 8'hA5, 8'h22};
        do_reset();
        push_good(8'h00, 2'b00);
        push_good(8'h11, 2'b00);
        push_good(8'h22, 2'b01);
        push_good(8'hA1, 2'b10);
        push_good(8'hA2, 2'b11);
        push_good(8'hA3, 2'b10);
        push_good(8'hA4, 2'b10);
        push_good(8'hA5, 2'b10);
        while (rec_n < 8 && g < 100) begin
            g++;
            @(negedge clk);
        end
        vec++; if (rec_n !== 8) begin
            miscmp++; $display("FAIL order_count got=%0d exp 8", rec_n);
        end
        for (int i = 0; i < 8; i++) begin
            vec++; if (rec[i] !== exp_ord[i]) begin
                miscmp++; $display("FAIL order_%0d got=%h exp=%h", i, rec[i], exp_ord[i]);
            end
        end
    endtask

    task automatic test_parity_reject();
        do_reset();
        push(8'h01, 2'b00, 1'b0);
        vec++; if (alarm !== 1'b1 || reject_count !== 4'd1) begin
            miscmp++; $display("FAIL reject_alarm alarm=%b cnt=%0d exp 1/1", alarm, reject_count);
        end
        vec++; if (vip_level !== 3'd0 || norm_level !== 3'd0) begin
            miscmp++; $display("FAIL reject_levels got=%0d/%0d exp 0/0", vip_level, norm_level);
        end
        @(negedge clk);
        vec++; if (alarm !== 1'b0 || admit_valid !== 1'b0 || admit_count !== 8'd0) begin
            miscmp++; $display("FAIL reject_after alarm=%b admit=%b cnt=%0d exp 0/0/0", alarm, admit_valid, admit_count);
        end
    endtask

    task automatic test_lockdown();
        int n = 0;
        do_reset();
        push_good(8'h10, 2'b00);
        push_good(8'h55, 2'b00);
        push_good(8'h66, 2'b00);
        @(negedge clk);
        push(8'h01, 2'b00, 1'b0);
        push(8'h02, 2'b10, 1'b0);
        push(8'h07, 2'b00, 1'b0);
        vec++; if (gate_open !== 1'b1 || locked !== 1'b0 || admit_token !== 8'h55) begin
            miscmp++; $display("FAIL lock_pre gate=%b locked=%b tok=%h exp 1/0/55", gate_open, locked, admit_token);
        end
        @(negedge clk);
        vec++; if (locked !== 1'b1 || gate_open !== 1'b0 || reject_count !== 4'd3) begin
            miscmp++; $display("FAIL lock_enter locked=%b gate=%b rej=%0d exp 1/0/3", locked, gate_open, reject_count);
        end
        while (!tok_ready && n < 30) begin
            n++;
            @(negedge clk);
        end
        vec++; if (n !== 8) begin
            miscmp++; $display("FAIL lock_ready_low cycles=%0d exp 8", n);
        end
        n = 0;
        while (!admit_valid && n < 20) begin
            n++;
            @(negedge clk);
        end
        vec++; if (admit_valid !== 1'b1 || admit_token !== 8'h66 || locked !== 1'b0) begin
            miscmp++; $display("FAIL lock_resume v=%b tok=%h locked=%b exp 1/66/0", admit_valid, admit_token, locked);
        end
    endtask

    task automatic test_full_sat();
        int g = 0;
        do_reset();
        push_good(8'hB1, 2'b10);
        push_good(8'hB2, 2'b10);
        push_good(8'hB3, 2'b10);
        push_good(8'hB4, 2'b10);
        push_good(8'hB5, 2'b10);
        vec++; if (vip_level !== 3'd4 || tok_ready !== 1'b0) begin
            miscmp++; $display("FAIL full_vip lvl=%0d ready=%b exp 4/0", vip_level, tok_ready);
        end
        while (!gate_open && g < 20) begin
            g++;
            @(negedge clk);
        end
        reset_n = 1'b0;
        @(negedge clk);
        vec++; if (gate_open !== 1'b0 || vip_level !== 3'd0 || admit_valid !== 1'b0 || admit_count !== 8'd0) begin
            miscmp++; $display("FAIL reset_mid_open gate=%b lvl=%0d v=%b cnt=%0d exp 0/0/0/0", gate_open, vip_level, admit_valid, admit_count);
        end
        reset_n = 1'b1;
        @(negedge clk);
        for (int i = 0; i < 17; i++) push(8'h01, 2'b00, 1'b0);
        vec++; if (reject_count !== 4'd15) begin
            miscmp++; $display("FAIL reject_saturate got=%0d exp 15", reject_count);
        end
    endtask

    initial begin
        test_reset();
        test_single_normal();
        test_priority_starve();
        test_parity_reject();
        test_lockdown();
        test_full_sat();
        $display("== %0d vectors applied, %0d miscompares ==", vec, miscmp);
        $finish;
    end

endmodule
